// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-organised RAM.
// Sub-word stores are performed as read-modify-write sequences.
// Loads return the selected lane, sign- or zero-extended.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN.
//   Defined:     misaligned halfword/word accesses respond with resp_err=1 and make no RAM access.
//   Not defined: misaligned accesses are force-aligned, and resp_err stays 0.
module mem_access_unit #(
    parameter int unsigned DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [DEPTH+1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             ram_we,
    output logic [DEPTH-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RDATA,
        S_WRITE,
        S_RESP
    } state_e;

    // Size encoding held internally: 0 = byte, 1 = halfword, 2 = word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             ram_we_q, ram_we_d;
    logic [DEPTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]      ram_wdata_q, ram_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [1:0]       req_size_n;
    logic [1:0]       req_lane;
    logic             trap;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [31:0]      merge_data;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

    // Size 3 behaves as a word; the lane is force-aligned to the access size.
    assign req_size_n = (req_size == 2'd3) ? SZ_WORD : req_size;
    assign req_lane   = (req_size_n == SZ_WORD) ? 2'b00 :
                        (req_size_n == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                  ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Lane extraction and sign/zero extension of the RAM read word for loads.
    always_comb begin
        byte_sel  = '0;
        half_sel  = '0;
        load_data = '0;
        case (lane_q)
            2'd0:    byte_sel = ram_rdata[7:0];
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            default: byte_sel = ram_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = ram_rdata;
        endcase
    end

    // Insert the latched store data into the addressed lane of the RAM read word.
    always_comb begin
        merge_data = ram_rdata;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merge_data[31:16] = wdata_q;
        end else begin
            merge_data[15:0] = wdata_q;
        end
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size_n;
                    uns_d      = req_unsigned;
                    lane_d     = req_lane;
                    wdata_d    = req_wdata[15:0];
                    ram_addr_d = req_addr[DEPTH+1:2];
                    if (trap) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else if (req_we && (req_size_n == SZ_WORD)) begin
                        ram_wdata_d = req_wdata;
                        ram_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (we_q) begin
                    ram_wdata_d = merge_data;
                    ram_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                ram_we_d     = 1'b0;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                ram_we_d     = 1'b0;
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the word-organised data RAM. Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake. Drives the RAM's write-enable, address and write-data inputs and consumes its registered read-data output. Sub-word stores become read-modify-write sequences; loads are returned byte/halfword-aligned and sign- or zero-extended.

## Interface
- `DEPTH`, 10, RAM word-address width; byte address is `DEPTH+2` bits.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `req_unsigned`  in  1  loads: zero-extend when 1, sign-extend when 0.
- `req_addr`  in  DEPTH+2  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned access (see Configuration).
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  DEPTH  RAM word address = `req_addr[DEPTH+1:2]`.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid one cycle after the read address is presented with `ram_we=0`.

## Operation
- States: IDLE, READ, RDATA, WRITE, RESP. All outputs are registered except `req_ready`, which is `state==IDLE`.
- **IDLE**
  - On `req_valid`, latch all `req_*` fields.
  - Misaligned request (with the macro defined): go to RESP with `resp_err=1`; no RAM access.
  - Word store: go to WRITE with `ram_wdata=req_wdata`.
  - All other requests: go to READ.
- **READ**: `ram_addr` is driven and `ram_we=0`; go to RDATA.
- **RDATA**: `ram_rdata` is valid.
  - Load: select the lane by `addr[1:0]` (byte) or `addr[1]` (halfword), extend it, and go to RESP.
  - Sub-word store: replace the addressed byte or halfword lane of `ram_rdata` with the low bits of the latched wdata, load the result into `ram_wdata`, and go to WRITE.
- **WRITE**: `ram_we=1` for exactly one cycle; go to RESP.
- **RESP**: `resp_valid=1` holds until `resp_ready`; on handshake, clear `resp_valid` and go to IDLE.
- `resp_rdata` and `resp_err` are stable while `resp_valid` is high.
- Little-endian lane order: byte 0 = bits 7:0.
- Only one request is in flight; no new request is accepted until the response handshake completes.
- Reset at any time: state=IDLE, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `req_ready=1`.
  - An interrupted store may leave its RAM write undone.
  - A write already performed is not rolled back.

## Timing
- Request accepted at edge E0 (IDLE, `req_valid`):
  - Word store: WRITE in E0+1 cycle, `resp_valid` in E0+2.
  - Load: READ E0+1, RDATA E0+2, `resp_valid` in E0+3.
  - Sub-word store: READ, RDATA, WRITE, `resp_valid` in E0+4.
  - Misaligned with trap: `resp_valid` in E0+1.
- With `resp_ready` held high, the next request can be accepted one cycle after `resp_valid` rises: RESP handshake, then IDLE.
- `ram_we` is never high in any state other than WRITE.
- Upper address bits above `DEPTH+1` do not exist, so no range error is possible.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]=1`, or a word with `addr[1:0]!=0`, gets `resp_err=1` and `resp_rdata=0`.
  - No RAM read or write is performed.
- Not defined:
  - Misaligned halfword/word accesses are force-aligned by clearing `addr[0]` or `addr[1:0]` respectively, and proceed normally.
  - `resp_err` is tied 0.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load 0x010 → `ram_we` pulses once with `ram_addr=4`; load returns 0xDEADBEEF, `resp_err=0`.
- Byte store 0xA5 to 0x011 over word 0x11223344 → RAM word becomes 0x1122A544; byte load 0x011 signed → 0xFFFFFFA5; unsigned → 0x000000A5.
- Halfword load 0x012 from 0x8001_7FFF signed → 0xFFFF8001; halfword store 0xBEEF to 0x012 → word 0xBEEF7FFF.
- Halfword load at 0x013 → with macro: `resp_err=1`, `resp_rdata=0`, no `ram_we`, response one cycle after accept; without macro: returns the halfword at 0x012.
- Hold `resp_ready=0` for 5 cycles after a load response → `resp_valid` and data stable, `req_ready=0`; new `req_valid` is ignored until the handshake.
- Assert `rst_n=0` during RDATA of a sub-word store → all outputs take reset values immediately; RAM word unchanged; next request handled normally.
